// File: rtl/uart_frame_mux.sv
// rtl/uart_frame_mux.sv - framed channel-word multiplexer feeding a byte-wide UART transmitter
// Frame: SYNC, header {seq, CHANNELS-1}, then {ID, word bytes MSB-first} per masked channel, then XOR checksum.
module uart_frame_mux #(
  parameter int         CHANNELS  = 4,
  parameter int         WORD_W    = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_GAP = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [CHANNELS*WORD_W-1:0] ch_data,
  input  logic [CHANNELS-1:0]        ch_mask,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [7:0]                 frame_cnt
);

  localparam int              NB       = WORD_W / 8;
  localparam int              GAP_W    = $clog2(FRAME_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [3:0]      CH_FIELD = 4'(CHANNELS - 1);
  localparam logic [2:0]      LAST_B   = 3'(NB - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HDR, S_ID, S_DATA, S_CSUM} state_t;

  state_t                     r_state, w_state_n;
  logic [GAP_W-1:0]           r_gap, w_gap_n;
  logic [CHANNELS*WORD_W-1:0] r_snap_data, w_snap_data_n;
  logic [CHANNELS-1:0]        r_snap_mask, w_snap_mask_n;
  logic [3:0]                 r_seq, w_seq_n;
  logic [7:0]                 r_csum, w_csum_n;
  logic [7:0]                 r_tx_data, w_tx_data_n;
  logic [7:0]                 r_frame_cnt, w_frame_cnt_n;
  logic [4:0]                 r_ch, w_ch_n;
  logic [2:0]                 r_byte, w_byte_n;
  logic                       w_accept;
  logic [4:0]                 w_search_from;
  logic                       w_found;
  logic [4:0]                 w_next_ch;
  logic                       w_advance;

  function automatic logic [7:0] word_byte(input logic [CHANNELS*WORD_W-1:0] d,
                                           input logic [4:0] ch, input logic [2:0] b);
    logic [CHANNELS*WORD_W-1:0] s;
    logic [WORD_W-1:0]          w;
    s = d >> (int'(ch) * WORD_W);
    w = s[WORD_W-1:0];
    w = w >> ((NB - 1 - int'(b)) * 8);
    return w[7:0];
  endfunction

  assign w_accept  = tx_valid & tx_ready;
  assign tx_valid  = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign tx_data   = r_tx_data;
  assign frame_cnt = r_frame_cnt;

  // Lowest masked channel at or above the search start; descending scan leaves the lowest hit.
  always_comb begin
    w_search_from = (r_state == S_HDR) ? 5'd0 : 5'(r_ch + 5'd1);
    w_found       = 1'b0;
    w_next_ch     = 5'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if ((int'(w_search_from) <= i) && r_snap_mask[i]) begin
        w_found   = 1'b1;
        w_next_ch = 5'(i);
      end
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_gap_n       = r_gap;
    w_snap_data_n = r_snap_data;
    w_snap_mask_n = r_snap_mask;
    w_seq_n       = r_seq;
    w_csum_n      = r_csum;
    w_tx_data_n   = r_tx_data;
    w_frame_cnt_n = r_frame_cnt;
    w_ch_n        = r_ch;
    w_byte_n      = r_byte;
    w_advance     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_gap == GAP_LAST) begin
          if (enable) begin
            w_state_n     = S_SYNC;
            w_snap_data_n = ch_data;
            w_snap_mask_n = ch_mask;
            w_gap_n       = '0;
            w_tx_data_n   = SYNC_BYTE;
            w_csum_n      = 8'h00;
          end
        end else begin
          w_gap_n = r_gap + 1'b1;
        end
      end
      S_SYNC: if (w_accept) begin
        w_state_n   = S_HDR;
        w_tx_data_n = {r_seq, CH_FIELD};
        w_csum_n    = {r_seq, CH_FIELD};
      end
      S_HDR: if (w_accept) w_advance = 1'b1;
      S_ID: if (w_accept) begin
        w_state_n   = S_DATA;
        w_byte_n    = 3'd0;
        w_tx_data_n = word_byte(r_snap_data, r_ch, 3'd0);
        w_csum_n    = r_csum ^ word_byte(r_snap_data, r_ch, 3'd0);
      end
      S_DATA: if (w_accept) begin
        if (r_byte == LAST_B) begin
          w_advance = 1'b1;
        end else begin
          w_byte_n    = r_byte + 3'd1;
          w_tx_data_n = word_byte(r_snap_data, r_ch, r_byte + 3'd1);
          w_csum_n    = r_csum ^ word_byte(r_snap_data, r_ch, r_byte + 3'd1);
        end
      end
      S_CSUM: if (w_accept) begin
        w_state_n     = S_IDLE;
        w_tx_data_n   = 8'h00;
        w_seq_n       = r_seq + 4'd1;
        w_frame_cnt_n = r_frame_cnt + 8'd1;
      end
      default: w_state_n = S_IDLE;
    endcase
    // The checksum register already holds every byte loaded so far, so it is sent as-is.
    if (w_advance) begin
      if (w_found) begin
        w_state_n   = S_ID;
        w_ch_n      = w_next_ch;
        w_tx_data_n = {3'b000, w_next_ch};
        w_csum_n    = r_csum ^ {3'b000, w_next_ch};
      end else begin
        w_state_n   = S_CSUM;
        w_tx_data_n = r_csum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_snap_data <= '0;
      r_snap_mask <= '0;
      r_seq       <= 4'd0;
      r_csum      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_frame_cnt <= 8'h00;
      r_ch        <= 5'd0;
      r_byte      <= 3'd0;
    end else begin
      r_state     <= w_state_n;
      r_gap       <= w_gap_n;
      r_snap_data <= w_snap_data_n;
      r_snap_mask <= w_snap_mask_n;
      r_seq       <= w_seq_n;
      r_csum      <= w_csum_n;
      r_tx_data   <= w_tx_data_n;
      r_frame_cnt <= w_frame_cnt_n;
      r_ch        <= w_ch_n;
      r_byte      <= w_byte_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_mux.sv
// tb/tb_uart_frame_mux.sv - scoreboard bench for uart_frame_mux with a frame-level reference model
module tb_uart_frame_mux;
  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int NB  = W / 8;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CH*W-1:0] ch_data;
  logic [CH-1:0] ch_mask;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic [7:0]    frame_cnt;

  uart_frame_mux #(.CHANNELS(CH), .WORD_W(W), .SYNC_BYTE(8'hA5), .FRAME_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_data(ch_data), .ch_mask(ch_mask),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [3:0] seq_m;
  logic [7:0] fcnt_m;
  int         checks   = 0;
  int         failures = 0;
  bit         rdy_mode = 1'b0;
  bit         gap_armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built straight from the frame layout rules.
  task automatic push_frame(input logic [CH-1:0] m, input logic [CH*W-1:0] d);
    logic [7:0] h, cs, b;
    q.push_back(8'hA5);
    h = {seq_m, 4'(CH - 1)};
    q.push_back(h);
    cs = h;
    for (int c = 0; c < CH; c++) begin
      if (m[c]) begin
        b = 8'(c);
        q.push_back(b);
        cs ^= b;
        for (int k = NB - 1; k >= 0; k--) begin
          b = d[c*W + 8*k +: 8];
          q.push_back(b);
          cs ^= b;
        end
      end
    end
    q.push_back(cs);
  endtask

  task automatic run_frame(input logic [CH-1:0] m, input logic [CH*W-1:0] d,
                           input logic [CH-1:0] pm, input logic [CH*W-1:0] pd, output int edges);
    bit seen, done;
    ch_mask = m;
    ch_data = d;
    enable  = 1'b1;
    push_frame(m, d);
    seen  = 1'b0;
    edges = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        seen  = 1'b1;
        edges = n;
        break;
      end
    end
    if (!seen) chk("start_timeout", 32'd0, 32'd1);
    enable  = 1'b0;
    ch_mask = pm;
    ch_data = pd;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("end_timeout", 32'd0, 32'd1);
    seq_m++;
    fcnt_m++;
    chk("frame_cnt", 32'(frame_cnt), 32'(fcnt_m));
    chk("bytes_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops expected bytes on each handshake and checks hold/gap behaviour.
  initial begin
    logic [7:0] exp_b, prev_data;
    bit         prev_valid, prev_ready;
    int         idle_run;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = 8'h00; idle_run = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("busy_eq_valid", 32'(busy), 32'(tx_valid));
        if (prev_valid && !prev_ready) begin
          chk("stall_valid", 32'(tx_valid), 32'd1);
          chk("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (!tx_valid) idle_run++;
        else begin
          if (gap_armed && idle_run != 0) chk("frame_gap", 32'(idle_run), 32'(GAP));
          idle_run = 0;
        end
        if (tx_valid && tx_ready) begin
          if (q.size() == 0) chk("unexpected_byte", 32'(tx_data), 32'h100);
          else begin
            exp_b = q.pop_front();
            chk("tx_byte", 32'(tx_data), 32'(exp_b));
          end
        end
        prev_valid = tx_valid; prev_ready = tx_ready; prev_data = tx_data;
      end else begin
        prev_valid = 1'b0;
        idle_run   = 0;
      end
    end
  end

  initial begin
    int e;
    bit hit;
    rst = 1'b0; enable = 1'b0; ch_data = '0; ch_mask = '0; tx_ready = 1'b1;
    seq_m = 4'd0; fcnt_m = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    run_frame(2'b11, 32'h4567_0123, 2'b11, 32'h4567_FFFF, e);
    chk("first_start_edge", 32'(e), 32'(GAP));
    gap_armed = 1'b1;
    run_frame(2'b11, 32'h4567_FFFF, 2'b01, 32'h0, e);
    run_frame(2'b10, 32'h4567_0123, 2'b11, 32'hDEAD_BEEF, e);
    run_frame(2'b00, 32'h4567_0123, 2'b11, 32'h1234_5678, e);
    rdy_mode = 1'b1;
    for (int i = 0; i < 270; i++)
      run_frame(CH'($urandom), $urandom, CH'($urandom), $urandom, e);
    gap_armed = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("enable_low_idle", 32'(tx_valid), 32'd0);
    chk("enable_low_fcnt", 32'(frame_cnt), 32'(fcnt_m));
    run_frame(2'b01, $urandom, 2'b10, $urandom, e);
    rdy_mode = 1'b0;
    ch_mask = 2'b11;
    ch_data = $urandom;
    enable  = 1'b1;
    push_frame(2'b11, ch_data);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (q.size() <= 4) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("midframe_timeout", 32'd0, 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_fcnt", 32'(frame_cnt), 32'd0);
    q.delete();
    seq_m = 4'd0; fcnt_m = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_frame(2'b11, 32'h4567_0123, 2'b00, 32'h0, e);
    chk("post_rst_start_edge", 32'(e), 32'(GAP));
    gap_armed = 1'b1;
    rdy_mode = 1'b1;
    for (int i = 0; i < 5; i++)
      run_frame(CH'($urandom), $urandom, CH'($urandom), $urandom, e);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
